wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the in-order writeback stage and a long-latency multiply/divide unit (MDU). The writeback stage is fed by the memory/writeback pipeline register and has already selected its result. MDU results are buffered in a small FIFO and drained into port slots the pipeline leaves idle. If an MDU result is starved, a stall request freezes the writeback stage for exactly one cycle so the result can be forced through.

---
 rtl/wb_port_arbiter.sv | 135 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the writeback stage shares the port with buffered MDU results,
// and a one-cycle stall request forces a starved MDU result through.
module wb_port_arbiter #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned BUF_DEPTH    = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  W_RegWrite,
   input  logic [4:0]            W_rd,
   input  logic [DATA_WIDTH-1:0] W_result,
   input  logic                  mdu_valid,
   input  logic [4:0]            mdu_rd,
   input  logic [DATA_WIDTH-1:0] mdu_data,
   output logic                  mdu_ready,
   output logic                  stall_req,
   output logic                  mdu_pending,
   output logic                  rf_we,
   output logic [4:0]            rf_rd,
   output logic [DATA_WIDTH-1:0] rf_wd
);

   localparam int unsigned PTR_W  = $clog2(BUF_DEPTH);
   localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + 1);
   localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, DRAIN, FORCE} state_t;

   logic [4:0]            rd_mem [BUF_DEPTH];
   logic [DATA_WIDTH-1:0] wd_mem [BUF_DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      count, count_nxt;
   logic [WAIT_W-1:0]     wait_cnt, wait_nxt;
   logic                  stall_nxt;
   logic                  push, pop, wb_ok;
   logic                  grant_we;
   logic [4:0]            grant_rd;
   logic [DATA_WIDTH-1:0] grant_wd;
   state_t                state_c;

   assign mdu_ready   = (count != CNT_W'(BUF_DEPTH));
   assign mdu_pending = (count != '0);
   assign push        = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
   assign wb_ok       = W_RegWrite && (W_rd != 5'd0);

   // State is a pure decode of the registered count and stall pulse
   always_comb begin
      state_c = IDLE;
      if (stall_req)
         state_c = FORCE;
      else if (count != '0)
         state_c = DRAIN;
   end

   always_comb begin
      pop       = 1'b0;
      grant_we  = 1'b0;
      grant_rd  = rf_rd;
      grant_wd  = rf_wd;
      wait_nxt  = wait_cnt;
      stall_nxt = 1'b0;
      case (state_c)
         FORCE: begin
            pop      = 1'b1;
            grant_we = 1'b1;
            grant_rd = rd_mem[rd_ptr];
            grant_wd = wd_mem[rd_ptr];
         end
         DRAIN: begin
            if (wb_ok) begin
               grant_we  = 1'b1;
               grant_rd  = W_rd;
               grant_wd  = W_result;
               if (wait_cnt != WAIT_W'(STARVE_LIMIT))
                  wait_nxt = wait_cnt + WAIT_W'(1);
               stall_nxt = (wait_cnt == WAIT_W'(STARVE_LIMIT - 1));
            end else begin
               pop      = 1'b1;
               grant_we = 1'b1;
               grant_rd = rd_mem[rd_ptr];
               grant_wd = wd_mem[rd_ptr];
            end
         end
         default: begin
            wait_nxt = '0;
            if (wb_ok) begin
               grant_we = 1'b1;
               grant_rd = W_rd;
               grant_wd = W_result;
            end
         end
      endcase
      if (pop)
         wait_nxt = '0;
      case ({push, pop})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         wait_cnt  <= '0;
         stall_req <= 1'b0;
         rf_we     <= 1'b0;
         rf_rd     <= '0;
         rf_wd     <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count     <= count_nxt;
         wait_cnt  <= wait_nxt;
         stall_req <= stall_nxt;
         rf_we     <= grant_we;
         rf_rd     <= grant_rd;
         rf_wd     <= grant_wd;
      end
   end

   // Storage needs no reset: entries are only read while counted
   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem[wr_ptr] <= mdu_rd;
         wd_mem[wr_ptr] <= mdu_data;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected register-file writes are queued by the
// stimulus and checked in order by a negedge monitor.
module tb_wb_port_arbiter;

   localparam int unsigned DW = 32;

   typedef struct packed {
      logic [4:0]    rd;
      logic [DW-1:0] wd;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          W_RegWrite = 1'b0;
   logic [4:0]    W_rd = '0;
   logic [DW-1:0] W_result = '0;
   logic          mdu_valid = 1'b0;
   logic [4:0]    mdu_rd = '0;
   logic [DW-1:0] mdu_data = '0;
   logic          mdu_ready, stall_req, mdu_pending, rf_we;
   logic [4:0]    rf_rd;
   logic [DW-1:0] rf_wd;

   int checks   = 0;
   int failures = 0;
   wr_t exp_q[$];

   wb_port_arbiter #(.DATA_WIDTH(DW), .BUF_DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .W_RegWrite(W_RegWrite), .W_rd(W_rd), .W_result(W_result),
      .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
      .mdu_ready(mdu_ready), .stall_req(stall_req), .mdu_pending(mdu_pending),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [4:0] rd, input logic [DW-1:0] wd);
      wr_t e;
      e.rd = rd;
      e.wd = wd;
      exp_q.push_back(e);
   endtask

   // Monitor: every write presented on the port must match the next expected write
   always @(negedge clk) begin
      if (!rst && rf_we) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rf_we", {27'd0, rf_rd, rf_wd}, 64'd0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("rf_write", {27'd0, rf_rd, rf_wd}, {27'd0, e.rd, e.wd});
         end
      end
   end

   initial begin
      // Asynchronous reset asserted between clock edges
      #2 rst = 1'b1;
      #1;
      chk("rst_rf_we", 64'(rf_we), 64'd0);
      chk("rst_rf_rd", 64'(rf_rd), 64'd0);
      chk("rst_rf_wd", 64'(rf_wd), 64'd0);
      chk("rst_stall", 64'(stall_req), 64'd0);
      chk("rst_pending", 64'(mdu_pending), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_rf_we", 64'(rf_we), 64'd0);
         chk("idle_ready", 64'(mdu_ready), 64'd1);
         chk("idle_pending", 64'(mdu_pending), 64'd0);
      end

      // Writeback only, then a writeback to x0
      W_RegWrite = 1'b1; W_rd = 5'd5; W_result = 32'hDEADBEEF;
      push_exp(5'd5, 32'hDEADBEEF);
      tick();
      chk("wb_rf_we", 64'(rf_we), 64'd1);
      chk("wb_rf_rd", 64'(rf_rd), 64'd5);
      chk("wb_rf_wd", 64'(rf_wd), 64'hDEADBEEF);
      W_rd = 5'd0; W_result = 32'h11111111;
      tick();
      chk("wb_x0_rf_we", 64'(rf_we), 64'd0);
      W_RegWrite = 1'b0;
      tick();

      // MDU result into an idle slot
      mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h1234;
      push_exp(5'd7, 32'h1234);
      tick();
      mdu_valid = 1'b0;
      chk("fill_pending_t1", 64'(mdu_pending), 64'd1);
      chk("fill_rf_we_t1", 64'(rf_we), 64'd0);
      tick();
      chk("fill_rf_we_t2", 64'(rf_we), 64'd1);
      chk("fill_rf_rd_t2", 64'(rf_rd), 64'd7);
      chk("fill_pending_t2", 64'(mdu_pending), 64'd0);
      tick();

      // MDU result to x0 is consumed without being stored
      mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'h5555;
      tick();
      mdu_valid = 1'b0;
      chk("x0_pending", 64'(mdu_pending), 64'd0);
      tick();
      chk("x0_rf_we", 64'(rf_we), 64'd0);
      tick();

      // Backpressure and starvation with writeback held busy
      W_RegWrite = 1'b1; W_rd = 5'd3; W_result = 32'h33333333;
      for (int i = 0; i <= 16; i++) begin
         logic exp_stall, exp_ready, exp_pend;
         exp_stall = (i == 5) || (i == 10) || (i == 15);
         exp_ready = !((i >= 2 && i <= 5) || (i >= 7 && i <= 10));
         exp_pend  = !(i == 0 || i == 16);
         mdu_valid = (i <= 6);
         if (i == 0) begin
            mdu_rd = 5'd10; mdu_data = 32'hAAAA0001;
         end else if (i == 1) begin
            mdu_rd = 5'd11; mdu_data = 32'hBBBB0002;
         end else begin
            mdu_rd = 5'd12; mdu_data = 32'hCCCC0003;
         end
         if (i == 5)       push_exp(5'd10, 32'hAAAA0001);
         else if (i == 10) push_exp(5'd11, 32'hBBBB0002);
         else if (i == 15) push_exp(5'd12, 32'hCCCC0003);
         else              push_exp(5'd3, 32'h33333333);
         chk($sformatf("bp_stall_c%0d", i), 64'(stall_req), 64'(exp_stall));
         chk($sformatf("bp_ready_c%0d", i), 64'(mdu_ready), 64'(exp_ready));
         chk($sformatf("bp_pending_c%0d", i), 64'(mdu_pending), 64'(exp_pend));
         tick();
      end
      W_RegWrite = 1'b0; mdu_valid = 1'b0;
      tick();
      tick();

      // Reset while two entries are queued
      W_RegWrite = 1'b1; W_rd = 5'd6; W_result = 32'h66666666;
      mdu_valid = 1'b1; mdu_rd = 5'd20; mdu_data = 32'h20202020;
      push_exp(5'd6, 32'h66666666);
      tick();
      mdu_rd = 5'd21; mdu_data = 32'h21212121;
      push_exp(5'd6, 32'h66666666);
      tick();
      mdu_valid = 1'b0;
      chk("mid_pending_before", 64'(mdu_pending), 64'd1);
      #6 rst = 1'b1;
      #1;
      chk("mid_rst_pending", 64'(mdu_pending), 64'd0);
      chk("mid_rst_ready", 64'(mdu_ready), 64'd1);
      chk("mid_rst_rf_we", 64'(rf_we), 64'd0);
      W_RegWrite = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_rf_we", 64'(rf_we), 64'd0);
         chk("post_rst_pending", 64'(mdu_pending), 64'd0);
      end

      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
